// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: decodes register usage, reads the regfile, stalls on
// scoreboarded RAW/WAW hazards and registers operands for execute.
module id_operand_stage #(
  parameter int XLEN       = 64,
  parameter bit WB_SAMECYC = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic rd_wen;
  } dec_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  dec_t        dec;
  logic [31:0] busy, busy_nxt;
  logic        clr1, clr2, clrd;
  logic        hazard, fire;

  assign opcode    = in_inst[6:0];
  assign rd        = in_inst[11:7];
  assign funct3    = in_inst[14:12];
  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    dec = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: dec.rd_wen = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
        dec.rs1_used = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      OP_OP, OP_OP32: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        dec.rd_wen   = 1'b1;
      end
      OP_SYSTEM: begin
        dec.rs1_used = 1'b1;
        dec.rd_wen   = (funct3 != 3'd0);
      end
      OP_BRANCH, OP_STORE: begin
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
      end
      default: dec = '0;
    endcase
    if (rd == 5'd0) dec.rd_wen = 1'b0;
  end

  // A same-cycle writeback relies on the regfile's write bypass to deliver fresh data.
  assign clr1 = WB_SAMECYC && wb_valid && (wb_rd == rs1);
  assign clr2 = WB_SAMECYC && wb_valid && (wb_rd == rs2);
  assign clrd = WB_SAMECYC && wb_valid && (wb_rd == rd);

  assign hazard = (dec.rs1_used && (rs1 != 5'd0) && busy[rs1] && !clr1)
                | (dec.rs2_used && (rs2 != 5'd0) && busy[rs2] && !clr2)
                | (dec.rd_wen && busy[rd] && !clrd);

  assign in_ready = rst_n && !hazard && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (fire && dec.rd_wen) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_inst    <= in_inst;
      out_rs1_val <= dec.rs1_used ? rf_rdata1 : '0;
      out_rs2_val <= dec.rs2_used ? rf_rdata2 : '0;
      out_rd      <= rd;
      out_rd_wen  <= dec.rd_wen;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized scoreboard bench for id_operand_stage against a set-of-pending-registers model.
module tb_id_operand_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [31:0]     in_inst = '0;
  logic [4:0]      rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_rd_wen;

  always #5 clk = ~clk;

  id_operand_stage #(.XLEN(XLEN), .WB_SAMECYC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen)
  );

  // Environment regfile: x0 reads 0, same-cycle writeback is bypassed.
  logic [XLEN-1:0] rf [32];
  always_comb begin
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    if (rf_raddr1 != 5'd0) rf_rdata1 = (wb_valid && wb_rd == rf_raddr1) ? wb_data : rf[rf_raddr1];
    if (rf_raddr2 != 5'd0) rf_rdata2 = (wb_valid && wb_rd == rf_raddr2) ? wb_data : rf[rf_raddr2];
  end

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] v1, v2;
    logic [4:0]      rd;
    logic            wen;
  } exp_t;

  exp_t q[$];
  bit   pend[32];
  bit   ov_m;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i, output bit u1, output bit u2, output bit w);
    logic [6:0] op = i[6:0];
    u1 = op inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b0110011, 7'b0011011,
                    7'b0111011, 7'b1110011, 7'b1100011, 7'b0100011};
    u2 = op inside {7'b1100011, 7'b0100011, 7'b0110011, 7'b0111011};
    w  = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                     7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011}
          || (op == 7'b1110011 && i[14:12] != 3'd0)) && (i[11:7] != 5'd0);
  endfunction

  function automatic logic [XLEN-1:0] regval(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (wb_valid && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  function automatic bit waits(input logic [4:0] r);
    return (r != 5'd0) && pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b0000011, 7'b0010011, 7'b0110011, 7'b0011011,
                             7'b0111011, 7'b1110011, 7'b1100011, 7'b0001111};
    logic [31:0] i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 11)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  // One clock of stimulus plus expected-handshake check and model commit.
  task automatic cycle(input bit rst, input bit allow_in);
    bit u1, u2, w, exp_rdy, fire;
    int pl[$];
    exp_t e;
    @(negedge clk);
    rst_n     = !rst;
    in_valid  = allow_in && ($urandom_range(0, 3) != 0);
    in_inst   = rand_inst();
    in_pc     = {$urandom, $urandom};
    out_ready = !allow_in || ($urandom_range(0, 3) != 0);
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = {$urandom, $urandom};
    if ($urandom_range(0, 9) < 4) begin
      for (int r = 1; r < 32; r++) if (pend[r]) pl.push_back(r);
      if (pl.size() > 0) begin
        wb_valid = 1'b1;
        wb_rd    = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      end
    end else if ($urandom_range(0, 19) == 0) begin
      wb_valid = 1'b1;
      wb_rd    = 5'($urandom_range(0, 31));
    end
    #1;
    ref_dec(in_inst, u1, u2, w);
    exp_rdy = !rst && !(u1 && waits(in_inst[19:15])) && !(u2 && waits(in_inst[24:20]))
              && !(w && waits(in_inst[11:7])) && (!ov_m || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, ov_m);
    fire = in_valid && exp_rdy;
    if (fire) begin
      e.pc   = in_pc;
      e.inst = in_inst;
      e.v1   = u1 ? regval(in_inst[19:15]) : '0;
      e.v2   = u2 ? regval(in_inst[24:20]) : '0;
      e.rd   = in_inst[11:7];
      e.wen  = w;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wb_valid) begin
      rf[wb_rd]   = wb_data;
      pend[wb_rd] = 1'b0;
    end
    if (fire && w) pend[in_inst[11:7]] = 1'b1;
    if (fire) ov_m = 1'b1;
    else if (ov_m && out_ready) ov_m = 1'b0;
    if (rst) begin
      foreach (pend[r]) pend[r] = 1'b0;
      ov_m = 1'b0;
      q.delete();
    end
  endtask

  // Monitor: the head entry must be presented (and held) whenever out_valid is high.
  always @(negedge clk) begin
    #2;
    if (rst_n !== 1'b0 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1'b1, 1'b0);
      end else begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_inst", {32'd0, out_inst}, {32'd0, q[0].inst});
        chk("out_rs1_val", out_rs1_val, q[0].v1);
        chk("out_rs2_val", out_rs2_val, q[0].v2);
        chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
        chk("out_rd_wen", {63'd0, out_rd_wen}, {63'd0, q[0].wen});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
    ov_m      = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0050_0093;  // addi x1,x0,5
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
    end
    chk("rst_out_pc", out_pc, '0);
    chk("rst_out_rs1", out_rs1_val, '0);
    chk("rst_out_rd_wen", {63'd0, out_rd_wen}, 64'd0);
    for (int n = 0; n < 2500; n++) cycle(n >= 1200 && n < 1202, 1'b1);
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0);
    chk("drain_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
